// File: rtl/arm_dmem_pkg.sv
// -----------------------------------------------------------------------------
// arm_dmem_pkg
// Shared declarations for the data-memory controller:
//   state_e    : controller FSM states (IDLE / WAIT / RESP)
//   LAT_W      : width of the wait-cycle counter (LATENCY range 0..15)
//   DEF_DATA_W : default data word width in bits
// Optional feature macro used by arm_dmem_ctrl: ARM_DMEM_ALIGN_CHK_EN
// -----------------------------------------------------------------------------
package arm_dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int LAT_W      = 4;
    localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/arm_dmem_array.sv
// -----------------------------------------------------------------------------
// arm_dmem_array
// DEPTH x DATA_W storage with one byte-enabled synchronous write port and one
// synchronous (registered) read port. Contents are never reset.
// Ports:
//   clk      : clock
//   wr_en    : write strobe
//   wr_addr  : write word index
//   wr_be    : per-byte write enables
//   wr_data  : write data
//   rd_en    : read strobe, loads rd_data on the same edge
//   rd_addr  : read word index
//   rd_data  : registered read data
// -----------------------------------------------------------------------------
module arm_dmem_array
    import arm_dmem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = 256,
    parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_W/8-1:0]   wr_be,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_W-1:0]     rd_data
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    // Single process for the whole array keeps every byte lane in one driver.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) begin
                    mem_r[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
                end
            end
        end
        if (rd_en) begin
            rd_data_q <= mem_r[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/arm_dmem_ctrl.sv
// -----------------------------------------------------------------------------
// arm_dmem_ctrl
// Single-outstanding data-memory controller with a programmable number of
// wait cycles before each response.
//
// Optional feature: define ARM_DMEM_ALIGN_CHK_EN to flag accesses whose
// sub-word address bits are non-zero as errors (no write, rdata=0). Without it
// those bits are ignored.
//
// Ports:
//   clk    : clock, all state changes on rising edge
//   reset  : asynchronous active-low reset
//   req    : access request, accepted when ready=1
//   we     : 1 = write, 0 = read
//   addr   : byte address
//   wdata  : write data
//   be     : byte enables (writes only)
//   ready  : high only in IDLE
//   rvalid : one-cycle response strobe (reads and writes)
//   rdata  : read data during rvalid, 0 otherwise
//   err    : out-of-range / misaligned access during rvalid, 0 otherwise
// -----------------------------------------------------------------------------
module arm_dmem_ctrl
    import arm_dmem_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  we,
    input  logic [31:0]           addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   be,
    output logic                  ready,
    output logic                  rvalid,
    output logic [DATA_W-1:0]     rdata,
    output logic                  err
);

    localparam int NB      = DATA_W / 8;
    localparam int BYTE_SH = $clog2(NB);
    localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // ------------------------------------------------------------------
    // State and capture registers
    // ------------------------------------------------------------------
    state_e              state_q,  state_d;
    logic [LAT_W-1:0]    cnt_q,    cnt_d;
    logic                ready_q,  ready_d;
    logic                rvalid_q, rvalid_d;
    logic                err_q,    err_d;
    logic                rd_sel_q, rd_sel_d;   // response carries array read data
    logic                we_q,     we_d;
    logic [31:0]         addr_q,   addr_d;
    logic [DATA_W-1:0]   wdata_q,  wdata_d;
    logic [NB-1:0]       be_q,     be_d;

    // ------------------------------------------------------------------
    // Current access view. With LATENCY=0 the response is entered on the
    // accept edge itself, before the capture registers hold the request,
    // so the live inputs are used while in IDLE.
    // ------------------------------------------------------------------
    logic                cur_we;
    logic [31:0]         cur_addr;
    logic [DATA_W-1:0]   cur_wdata;
    logic [NB-1:0]       cur_be;

    always_comb begin
        if (state_q == IDLE) begin
            cur_we    = we;
            cur_addr  = addr;
            cur_wdata = wdata;
            cur_be    = be;
        end else begin
            cur_we    = we_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
            cur_be    = be_q;
        end
    end

    // ------------------------------------------------------------------
    // Error decode
    // ------------------------------------------------------------------
    logic [31:0]   cur_word;
    logic [AW-1:0] cur_idx;
    logic          cur_oob;
    logic          cur_misalign;
    logic          cur_bad;

    assign cur_word = cur_addr >> BYTE_SH;
    assign cur_idx  = cur_word[AW-1:0];
    assign cur_oob  = (cur_word >= 32'(DEPTH));

`ifdef ARM_DMEM_ALIGN_CHK_EN
    localparam logic [31:0] LOW_MASK = 32'((1 << BYTE_SH) - 1);
    assign cur_misalign = |(cur_addr & LOW_MASK);
`else
    assign cur_misalign = 1'b0;
`endif

    // Misalignment and range errors share one response.
    assign cur_bad = cur_oob | cur_misalign;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    logic enter_resp;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        enter_resp = 1'b0;

        case (state_q)
            IDLE: begin
                // ready is always high in IDLE, so req alone accepts.
                if (req) begin
                    we_d    = we;
                    addr_d  = addr;
                    wdata_d = wdata;
                    be_d    = be;
                    if (LATENCY == 0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = LAT_W'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - LAT_W'(1);
                end
            end
            RESP: begin
                // Always drop back to IDLE: at least one ready cycle between accesses.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        ready_d  = (state_d == IDLE);
        rvalid_d = enter_resp;
        err_d    = enter_resp & cur_bad;
        rd_sel_d = enter_resp & ~cur_bad & ~cur_we;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ready_q  <= 1'b1;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rd_sel_q <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rd_sel_q <= rd_sel_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
        end
    end

    // ------------------------------------------------------------------
    // Storage. Write commit and read launch happen on the edge that enters
    // RESP; qualifying with reset keeps an edge during reset from touching
    // the array (relevant for LATENCY=0 where IDLE can enter RESP directly).
    // ------------------------------------------------------------------
    logic              arr_wr_en;
    logic              arr_rd_en;
    logic [DATA_W-1:0] arr_rd_data;

    assign arr_wr_en = reset & enter_resp &  cur_we & ~cur_bad;
    assign arr_rd_en = reset & enter_resp & ~cur_we & ~cur_bad;

    arm_dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_array (
        .clk     (clk),
        .wr_en   (arr_wr_en),
        .wr_addr (cur_idx),
        .wr_be   (cur_be),
        .wr_data (cur_wdata),
        .rd_en   (arr_rd_en),
        .rd_addr (cur_idx),
        .rd_data (arr_rd_data)
    );

    // ------------------------------------------------------------------
    // Outputs. The array read register is not reset, so rdata is gated by
    // the registered select to hold 0 outside a good read response.
    // ------------------------------------------------------------------
    assign ready  = ready_q;
    assign rvalid = rvalid_q;
    assign err    = err_q;
    assign rdata  = rd_sel_q ? arr_rd_data : '0;

endmodule
